// File: rtl/cache_pkg.sv
// Shared definitions for the cache request front-end.
//   fe_state_e  : front-end sequencer states (IDLE, PROBE, WAIT)
//   cache_req_t : one buffered request {write, addr, wdata} at default widths
//   DEFAULT_*   : default word and address widths used by the front-end
package cache_pkg;

   localparam int DEFAULT_DATA_WIDTH = 10;
   localparam int DEFAULT_ADDR_WIDTH = 13;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROBE = 2'd1,
      WAIT  = 2'd2
   } fe_state_e;

   typedef struct packed {
      logic                          write;
      logic [DEFAULT_ADDR_WIDTH-1:0] addr;
      logic [DEFAULT_DATA_WIDTH-1:0] wdata;
   } cache_req_t;

endpackage

// File: rtl/cache_frontend_if.sv
// Bundle of every non-clock signal of the cache front-end.
//   req_*  : upstream request channel (valid/ready)
//   rsp_*  : registered one-cycle completion pulse, no backpressure
//   c_*    : level-held read/write/ready interface to the cache
//   stat_* : hit/miss statistics and clear, plus busy
// Modports: slave = the front-end itself, master = its environment
// (processor side plus cache side).
interface cache_frontend_if
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int CNT_WIDTH  = 16
);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;

   logic                  rsp_valid;
   logic                  rsp_write;
   logic [DATA_WIDTH-1:0] rsp_data;

   logic [ADDR_WIDTH-1:0] c_addr;
   logic                  c_read;
   logic                  c_write;
   logic [DATA_WIDTH-1:0] c_write_data;
   logic [DATA_WIDTH-1:0] c_data;
   logic                  c_ready;

   logic                  stat_clr;
   logic [CNT_WIDTH-1:0]  hit_cnt;
   logic [CNT_WIDTH-1:0]  miss_cnt;
   logic                  busy;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  c_data, c_ready, stat_clr,
      output req_ready, rsp_valid, rsp_write, rsp_data,
      output c_addr, c_read, c_write, c_write_data,
      output hit_cnt, miss_cnt, busy
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output c_data, c_ready, stat_clr,
      input  req_ready, rsp_valid, rsp_write, rsp_data,
      input  c_addr, c_read, c_write, c_write_data,
      input  hit_cnt, miss_cnt, busy
   );

endinterface

// File: rtl/req_fifo.sv
// Small request FIFO with a combinationally visible head entry.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   push/din : write din when push and not full
//   pop      : drop the head when pop and not empty
//   head     : current oldest entry (valid while !empty)
//   count    : occupancy, $clog2(DEPTH)+1 bits; full/empty flags
// DEPTH must be a power of two so the pointers wrap naturally.
module req_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/cache_frontend.sv
// Request front-end placed directly before the cache.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cache_frontend_if.slave carrying the request channel,
//              registered response pulse, cache read/write/ready port and
//              hit/miss statistics.
// Requests are buffered in req_fifo and offered to the cache one at a time.
// The cache port is held unchanged for a whole PROBE/WAIT episode and only
// moves on the edge that completes a request, so a write is seen once.
module cache_frontend
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic             clk,
   input  logic             rst,
   cache_frontend_if.slave  bus
);

   localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int CW    = $clog2(DEPTH) + 1;

   fe_state_e             state_reg;
   fe_state_e             state_next;

   logic [REQ_W-1:0]      fifo_din;
   logic [REQ_W-1:0]      fifo_head;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  complete;
   logic                  more_pending;

   logic                  head_write;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_wdata;

   logic                  c_read_next;
   logic                  c_write_next;
   logic [ADDR_WIDTH-1:0] c_addr_next;
   logic [DATA_WIDTH-1:0] c_wdata_next;

   logic                  hit_inc;
   logic                  miss_inc;
   logic [1:0]            stat_inc;

   logic                  rsp_valid_reg;
   logic                  rsp_write_reg;
   logic [DATA_WIDTH-1:0] rsp_data_reg;

   // ---------------- request buffer ----------------
   assign push     = bus.req_valid && !fifo_full;
   assign fifo_din = {bus.req_write, bus.req_addr, bus.req_wdata};

   req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (complete),
      .din   (fifo_din),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_write = fifo_head[REQ_W-1];
   assign head_addr  = fifo_head[DATA_WIDTH +: ADDR_WIDTH];
   assign head_wdata = fifo_head[DATA_WIDTH-1:0];

   // Something is still queued after this completion: either more than the
   // head is stored, or a new request lands on the same edge.
   assign more_pending = (fifo_count > CW'(1)) || push;

   // ---------------- sequencer ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      complete     = 1'b0;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      c_read_next  = 1'b0;
      c_write_next = 1'b0;
      c_addr_next  = '0;
      c_wdata_next = '0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               state_next = PROBE;
            end
         end
         PROBE: begin
            c_read_next  = ~head_write;
            c_write_next = head_write;
            c_addr_next  = head_addr;
            c_wdata_next = head_wdata;
            if (bus.c_ready) begin
               complete   = 1'b1;
               hit_inc    = 1'b1;
               state_next = more_pending ? PROBE : IDLE;
            end else begin
               miss_inc   = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            c_read_next  = ~head_write;
            c_write_next = head_write;
            c_addr_next  = head_addr;
            c_wdata_next = head_wdata;
            if (bus.c_ready) begin
               complete   = 1'b1;
               state_next = more_pending ? PROBE : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------- registered response ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_reg <= 1'b0;
         rsp_write_reg <= 1'b0;
         rsp_data_reg  <= '0;
      end else begin
         rsp_valid_reg <= complete;
         if (complete) begin
            rsp_write_reg <= head_write;
            rsp_data_reg  <= head_write ? '0 : bus.c_data;
         end
      end
   end

   // ---------------- saturating statistics (index 0 = hit, 1 = miss) ----------------
   assign stat_inc = {miss_inc, hit_inc};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_stat
         logic [CNT_WIDTH-1:0] cnt_reg;
         // Clear has priority over a coincident increment.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if (bus.stat_clr) begin
               cnt_reg <= '0;
            end else if (stat_inc[gi] && (cnt_reg != '1)) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   endgenerate

   // ---------------- outputs ----------------
   assign bus.req_ready    = !fifo_full;
   assign bus.rsp_valid    = rsp_valid_reg;
   assign bus.rsp_write    = rsp_write_reg;
   assign bus.rsp_data     = rsp_data_reg;
   assign bus.c_read       = c_read_next;
   assign bus.c_write      = c_write_next;
   assign bus.c_addr       = c_addr_next;
   assign bus.c_write_data = c_wdata_next;
   assign bus.hit_cnt      = g_stat[0].cnt_reg;
   assign bus.miss_cnt     = g_stat[1].cnt_reg;
   assign bus.busy         = (state_reg != IDLE) || !fifo_empty;

endmodule
